// File: rtl/heap_drv_pkg.sv
// Shared opcodes, tagged-word constants and driver state encoding for the
// heap driver and the linked-memory allocator it controls.
package heap_drv_pkg;

    localparam int unsigned WORD_SZ = 16;

    typedef enum logic [2:0] {
        OP_ALLOC      = 3'd0,
        OP_FREE       = 3'd1,
        OP_ALLOC_FREE = 3'd2,
        OP_READ       = 3'd3,
        OP_WRITE      = 3'd4,
        OP_TAKE       = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAKE2 = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [WORD_SZ-1:0] UNDEF    = 16'h0000;
    localparam logic [WORD_SZ-1:0] NIL      = 16'h0001;
    localparam logic [WORD_SZ-1:0] UNIT     = 16'h0004;
    localparam logic [WORD_SZ-1:0] TAG_MASK = 16'hF000;
    localparam logic [WORD_SZ-1:0] TAG_INT  = 16'h8000;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_TAKE;
    endfunction

endpackage

// File: rtl/heap_drv_if.sv
// Command/response handshake between the evaluator core (master) and the
// heap driver (slave).
interface heap_drv_if #(
    parameter int DATA_SZ = 16
);
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [2:0]         i_cmd_op;
    logic [DATA_SZ-1:0] i_cmd_a;
    logic [DATA_SZ-1:0] i_cmd_b;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [2:0]         o_rsp_op;
    logic [DATA_SZ-1:0] o_rsp_data;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_a, i_cmd_b, i_rsp_ready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_op, o_rsp_data
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_a, i_cmd_b, i_rsp_ready,
        output o_cmd_ready, o_rsp_valid, o_rsp_op, o_rsp_data
    );
endinterface

// File: rtl/heap_drv_rsp_fifo.sv
// Two-entry {op,data} response queue; an empty queue presents UNDEF data.
module heap_drv_rsp_fifo
    import heap_drv_pkg::*;
#(
    parameter int DATA_SZ = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               push_i,
    input  logic [2:0]         push_op_i,
    input  logic [DATA_SZ-1:0] push_data_i,
    input  logic               pop_i,
    output logic               valid_o,
    output logic [2:0]         op_o,
    output logic [DATA_SZ-1:0] data_o,
    output logic [1:0]         count_o
);

    logic [2:0]         op_q   [2];
    logic [DATA_SZ-1:0] data_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // NOTE: storage is deliberately left out of reset; count_q alone decides validity.
    always_ff @(posedge i_clk) begin
        if (push_i) begin
            op_q[wr_ptr_q]   <= push_op_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign op_o    = valid_o ? op_q[rd_ptr_q]   : 3'd0;
    assign data_o  = valid_o ? data_q[rd_ptr_q] : DATA_SZ'(UNDEF);
    assign count_o = count_q;

    overflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push_i && !pop_i && count_q == 2'd2));
    underflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
        !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/heap_drv.sv
// Heap command driver: turns handshaked commands into one-cycle allocator
// strobes, sequences TAKE as read-then-free, and queues tagged results.
module heap_drv
    import heap_drv_pkg::*;
#(
    parameter int DATA_SZ   = 16,
    parameter int RSP_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    heap_drv_if.slave          bus,
    output logic               o_alloc,
    output logic [DATA_SZ-1:0] o_data,
    input  logic [DATA_SZ-1:0] i_addr,
    output logic               o_free,
    output logic [DATA_SZ-1:0] o_faddr,
    output logic               o_wr,
    output logic [DATA_SZ-1:0] o_waddr,
    output logic [DATA_SZ-1:0] o_wdata,
    output logic               o_rd,
    output logic [DATA_SZ-1:0] o_raddr,
    input  logic [DATA_SZ-1:0] i_rdata,
    input  logic               i_err,
    output logic               o_halt
);

    localparam logic [2:0] DEPTH = 3'(RSP_DEPTH);

    state_e             state_q, state_d;
    logic               halt_q, halt_d;
    logic               pend_v_q, pend_v_d;
    logic [2:0]         pend_op_q, pend_op_d;
    logic [DATA_SZ-1:0] take_addr_q, take_addr_d;

    logic               pop, push, accept, fault;
    logic [1:0]         count;
    logic [2:0]         occ;
    logic [DATA_SZ-1:0] push_data;

    assign pop    = bus.o_rsp_valid && bus.i_rsp_ready;
    assign occ    = {1'b0, count} + {2'b00, pend_v_q};
    assign bus.o_cmd_ready = (state_q == IDLE) && !halt_q && !i_rst && ((occ < DEPTH) || pop);
    assign accept = bus.i_cmd_valid && bus.o_cmd_ready;
    assign fault  = i_err || (accept && !op_legal(bus.i_cmd_op));
    assign push   = pend_v_q && !fault;
    assign o_halt = halt_q;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        o_alloc = 1'b0;
        o_data  = '0;
        o_free  = 1'b0;
        o_faddr = '0;
        o_wr    = 1'b0;
        o_waddr = '0;
        o_wdata = '0;
        o_rd    = 1'b0;
        o_raddr = '0;
        if (!i_rst && !halt_q) begin
            if (state_q == TAKE2) begin
                o_free  = 1'b1;
                o_faddr = take_addr_q;
            end else if (accept) begin
                case (bus.i_cmd_op)
                    OP_ALLOC:      begin o_alloc = 1'b1; o_data = bus.i_cmd_a; end
                    OP_FREE:       begin o_free = 1'b1; o_faddr = bus.i_cmd_a; end
                    OP_ALLOC_FREE: begin
                        o_alloc = 1'b1; o_data  = bus.i_cmd_a;
                        o_free  = 1'b1; o_faddr = bus.i_cmd_b;
                    end
                    OP_READ:       begin o_rd = 1'b1; o_raddr = bus.i_cmd_a; end
                    OP_WRITE:      begin o_wr = 1'b1; o_waddr = bus.i_cmd_b; o_wdata = bus.i_cmd_a; end
                    OP_TAKE:       begin o_rd = 1'b1; o_raddr = bus.i_cmd_a; end
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        pend_v_d    = 1'b0;
        pend_op_d   = pend_op_q;
        take_addr_d = take_addr_q;
        case (state_q)
            IDLE:    if (accept && bus.i_cmd_op == OP_TAKE) begin
                         state_d     = TAKE2;
                         take_addr_d = bus.i_cmd_a;
                     end
            TAKE2:   state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
        if (accept && op_legal(bus.i_cmd_op)) begin
            pend_v_d  = 1'b1;
            pend_op_d = bus.i_cmd_op;
        end
        if (fault) begin
            state_d  = HALT;
            halt_d   = 1'b1;
            pend_v_d = 1'b0;
        end
    end

    always_comb begin
        case (pend_op_q)
            OP_ALLOC, OP_ALLOC_FREE: push_data = i_addr;
            OP_READ, OP_TAKE:        push_data = i_rdata;
            default:                 push_data = DATA_SZ'(UNIT);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            halt_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_op_q   <= OP_ALLOC;
            take_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            pend_v_q    <= pend_v_d;
            pend_op_q   <= pend_op_d;
            take_addr_q <= take_addr_d;
        end
    end

    heap_drv_rsp_fifo #(.DATA_SZ(DATA_SZ)) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .push_i      (push),
        .push_op_i   (pend_op_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (bus.o_rsp_valid),
        .op_o        (bus.o_rsp_op),
        .data_o      (bus.o_rsp_data),
        .count_o     (count)
    );

endmodule

// File: tb/tb_heap_drv.sv
// Directed bench for heap_drv with a small behavioural allocator that answers
// strobes one edge later.
module tb_heap_drv;
    import heap_drv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_alloc, o_free, o_wr, o_rd, o_halt;
    logic [15:0] o_data, o_faddr, o_waddr, o_wdata, o_raddr;
    logic [15:0] i_addr = 16'h0000;
    logic [15:0] i_rdata = 16'h0000;
    logic        i_err = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    heap_drv_if #(.DATA_SZ(16)) bus ();

    heap_drv #(.DATA_SZ(16), .RSP_DEPTH(2)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus),
        .o_alloc (o_alloc),
        .o_data  (o_data),
        .i_addr  (i_addr),
        .o_free  (o_free),
        .o_faddr (o_faddr),
        .o_wr    (o_wr),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_rd    (o_rd),
        .o_raddr (o_raddr),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .o_halt  (o_halt)
    );

    always #5 clk = ~clk;

    // Allocator stand-in: fresh cells from 0x5000 upward, freed cells reused LIFO.
    logic [15:0] amem [0:65535];
    logic [15:0] fstack [$];
    logic [15:0] fresh = 16'h5000;
    always @(posedge clk) begin
        logic [15:0] ad;
        if (o_alloc) begin
            if (fstack.size() > 0) ad = fstack.pop_back();
            else begin ad = fresh; fresh = fresh + 16'd1; end
            amem[ad] = o_data;
            i_addr <= ad;
        end
        if (o_wr) amem[o_waddr] = o_wdata;
        if (o_rd) i_rdata <= amem[o_raddr];
        if (o_free) fstack.push_back(o_faddr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = op;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
    endtask

    task automatic idle();
        bus.i_cmd_valid = 1'b0;
    endtask

    initial begin
        idle();
        bus.i_cmd_op = 3'd0; bus.i_cmd_a = 16'h0; bus.i_cmd_b = 16'h0;
        bus.i_rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", bus.o_cmd_ready, 0);
        check("rst_rsp_valid", bus.o_rsp_valid, 0);
        check("rst_rsp_data", bus.o_rsp_data, 16'h0000);
        check("rst_halt", o_halt, 0);
        check("rst_strobes", {o_alloc, o_free, o_wr, o_rd}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.o_cmd_ready, 1);

        // Back-to-back ALLOCs
        @(negedge clk); cmd(OP_ALLOC, 16'h8005, 16'h0); #1;
        check("alloc1_strobe", {o_alloc, o_data}, {1'b1, 16'h8005});
        @(negedge clk); cmd(OP_ALLOC, 16'h8006, 16'h0); #1;
        check("alloc2_ready", bus.o_cmd_ready, 1);
        check("alloc2_no_rsp_yet", bus.o_rsp_valid, 0);
        @(negedge clk); idle(); #1;
        check("alloc1_rsp", {bus.o_rsp_valid, bus.o_rsp_op, bus.o_rsp_data}, {1'b1, OP_ALLOC, 16'h5000});
        @(negedge clk); #1;
        check("alloc2_rsp", {bus.o_rsp_valid, bus.o_rsp_op, bus.o_rsp_data}, {1'b1, OP_ALLOC, 16'h5001});
        @(negedge clk); #1;
        check("alloc_drained", bus.o_rsp_valid, 0);

        // WRITE then READ
        @(negedge clk); cmd(OP_WRITE, 16'h1234, 16'h5000); #1;
        check("write_strobe", {o_wr, o_waddr, o_wdata}, {1'b1, 16'h5000, 16'h1234});
        @(negedge clk); cmd(OP_READ, 16'h5000, 16'h0); #1;
        check("read_strobe", {o_rd, o_raddr}, {1'b1, 16'h5000});
        @(negedge clk); idle(); #1;
        check("write_rsp", {bus.o_rsp_op, bus.o_rsp_data}, {OP_WRITE, 16'h0004});
        @(negedge clk); #1;
        check("read_rsp", {bus.o_rsp_op, bus.o_rsp_data}, {OP_READ, 16'h1234});
        @(negedge clk); #1;
        check("rw_drained", bus.o_rsp_valid, 0);

        // TAKE: read, then free next cycle, then reuse of the freed cell
        @(negedge clk); cmd(OP_TAKE, 16'h5001, 16'h0); #1;
        check("take_rd", {o_rd, o_raddr, o_free}, {1'b1, 16'h5001, 1'b0});
        @(negedge clk); cmd(OP_ALLOC, 16'h8007, 16'h0); #1;
        check("take2_free", {o_free, o_faddr, o_rd, o_alloc}, {1'b1, 16'h5001, 1'b0, 1'b0});
        check("take2_ready", bus.o_cmd_ready, 0);
        @(negedge clk); #1;
        check("take_rsp", {bus.o_rsp_valid, bus.o_rsp_op, bus.o_rsp_data}, {1'b1, OP_TAKE, 16'h8006});
        check("after_take_ready", {bus.o_cmd_ready, o_alloc}, 2'b11);
        @(negedge clk); idle(); #1;
        check("take_popped", bus.o_rsp_valid, 0);
        @(negedge clk); #1;
        check("realloc_rsp", {bus.o_rsp_op, bus.o_rsp_data}, {OP_ALLOC, 16'h5001});
        @(negedge clk); #1;
        check("take_drained", bus.o_rsp_valid, 0);

        // Back-pressure: only two ALLOCs fit while the consumer stalls
        bus.i_rsp_ready = 1'b0;
        @(negedge clk); cmd(OP_ALLOC, 16'h9001, 16'h0); #1;
        check("bp_ready0", bus.o_cmd_ready, 1);
        @(negedge clk); cmd(OP_ALLOC, 16'h9002, 16'h0); #1;
        check("bp_ready1", bus.o_cmd_ready, 1);
        @(negedge clk); cmd(OP_ALLOC, 16'h9003, 16'h0); #1;
        check("bp_stall1", {bus.o_cmd_ready, o_alloc}, 2'b00);
        check("bp_head", bus.o_rsp_data, 16'h5002);
        @(negedge clk); #1;
        check("bp_stall2", {bus.o_cmd_ready, bus.o_rsp_valid}, 2'b01);
        bus.i_rsp_ready = 1'b1; #1;
        check("bp_release_ready", bus.o_cmd_ready, 1);
        @(negedge clk); cmd(OP_ALLOC, 16'h9004, 16'h0); #1;
        check("bp_rsp2", bus.o_rsp_data, 16'h5003);
        check("bp_pop_ready", bus.o_cmd_ready, 1);
        @(negedge clk); idle(); #1;
        check("bp_rsp3", bus.o_rsp_data, 16'h5004);
        @(negedge clk); #1;
        check("bp_rsp4", bus.o_rsp_data, 16'h5005);
        @(negedge clk); #1;
        check("bp_drained", bus.o_rsp_valid, 0);

        // Illegal opcode halts; queued response still drains
        bus.i_rsp_ready = 1'b0;
        @(negedge clk); cmd(OP_READ, 16'h5000, 16'h0);
        @(negedge clk); idle();
        @(negedge clk); cmd(3'd7, 16'h0, 16'h0); #1;
        check("ill_no_strobes", {o_alloc, o_free, o_wr, o_rd}, 0);
        @(negedge clk); cmd(OP_ALLOC, 16'h1111, 16'h0); #1;
        check("ill_halt", {o_halt, bus.o_cmd_ready, o_alloc}, 3'b100);
        check("ill_queue_kept", {bus.o_rsp_valid, bus.o_rsp_op, bus.o_rsp_data}, {1'b1, OP_READ, 16'h1234});
        bus.i_rsp_ready = 1'b1;
        @(negedge clk); idle(); #1;
        check("ill_drained", {bus.o_rsp_valid, o_halt}, 2'b01);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check("ill_rst_clear", {o_halt, bus.o_cmd_ready}, 2'b01);

        // Allocator error halts
        @(negedge clk); i_err = 1'b1;
        @(negedge clk); i_err = 1'b0; cmd(OP_ALLOC, 16'h2222, 16'h0); #1;
        check("err_halt", {o_halt, bus.o_cmd_ready, o_alloc}, 3'b100);
        idle();
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check("err_rst_clear", {o_halt, bus.o_cmd_ready}, 2'b01);

        // Reset during TAKE2 abandons the free
        @(negedge clk); cmd(OP_TAKE, 16'h5000, 16'h0); #1;
        check("rt_rd", o_rd, 1);
        @(negedge clk); idle(); rst = 1'b1; #1;
        check("rt_no_free", o_free, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("rt_after", {bus.o_cmd_ready, bus.o_rsp_valid, o_free, o_halt}, 4'b1000);
        check("rt_rsp_data", bus.o_rsp_data, 16'h0000);

        // ALLOC_FREE raises both strobes
        @(negedge clk); cmd(OP_ALLOC_FREE, 16'hBEEF, 16'h5002); #1;
        check("af_strobes", {o_alloc, o_free, o_data, o_faddr}, {2'b11, 16'hBEEF, 16'h5002});
        @(negedge clk); idle();
        @(negedge clk); #1;
        check("af_rsp", {bus.o_rsp_valid, bus.o_rsp_op, bus.o_rsp_data}, {1'b1, OP_ALLOC_FREE, 16'h5006});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
